// File: rtl/out_channel_drain.sv
// out_channel_drain: FIFO between the program-runner core's `out` port and a
// valid/ready consumer. Flags dropped or late words and reports when the
// program has finished and every emitted word has been consumed.
module out_channel_drain #(
  parameter int unsigned MemoryElementWidth = 12,
  parameter int unsigned NOut               = 3,
  parameter int unsigned CountWidth         = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          outValid,
  input  logic [MemoryElementWidth-1:0] outData,
  input  logic                          programFinished,
  output logic                          streamValid,
  output logic [MemoryElementWidth-1:0] streamData,
  input  logic                          streamReady,
  output logic [CountWidth-1:0]         count,
  output logic                          error,
  output logic                          drained
);

  localparam int unsigned PtrW = (NOut > 1) ? $clog2(NOut) : 1;

  typedef logic [MemoryElementWidth-1:0] word_t;

  word_t                 mem_q [NOut];
  word_t                 mem_d [NOut];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  error_q, error_d;
  logic                  drained_q, drained_d;
  logic                  pop;
  logic                  push_ok;

  // Pointers wrap at NOut-1 so any depth works, not only powers of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(NOut - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Next-state: pop/push decode, occupancy, sticky error and drained flags.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    error_d   = error_q;
    drained_d = drained_q;

    pop     = (count_q != '0) && streamReady;
    // Full buffer still accepts when the head leaves in the same cycle.
    push_ok = outValid && !drained_q &&
              ((count_q < CountWidth'(NOut)) || pop);

    if (push_ok) begin
      mem_d[wr_ptr_q] = outData;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    if (push_ok && !pop) begin
      count_d = count_q + CountWidth'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CountWidth'(1);
    end

    // Overflow and writes after drain both drop the word.
    if (outValid && !push_ok) begin
      error_d = 1'b1;
    end
    // Uses the pre-edge count, so a final pop sets drained one edge later.
    if (programFinished && (count_q == '0) && !outValid) begin
      drained_d = 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NOut); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      error_q   <= 1'b0;
      drained_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      error_q   <= error_d;
      drained_q <= drained_d;
    end
  end

  // Outputs decoded purely from registers; no path from outValid.
  always_comb begin
    streamValid = (count_q != '0);
    streamData  = streamValid ? mem_q[rd_ptr_q] : '0;
    count       = count_q;
    error       = error_q;
    drained     = drained_q;
  end

endmodule

// File: tb/tb_out_channel_drain.sv
// Self-checking bench for out_channel_drain: queue-based reference model
// compared every cycle, plus literal expectations per directed scenario.
module tb_out_channel_drain;

  localparam int unsigned W    = 12;
  localparam int unsigned NOUT = 3;
  localparam int unsigned CW   = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          outValid;
  logic [W-1:0]  outData;
  logic          programFinished;
  logic          streamValid;
  logic [W-1:0]  streamData;
  logic          streamReady;
  logic [CW-1:0] count;
  logic          error;
  logic          drained;

  int checks = 0;
  int errors = 0;

  out_channel_drain #(
    .MemoryElementWidth(W),
    .NOut(NOUT),
    .CountWidth(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .outValid(outValid),
    .outData(outData),
    .programFinished(programFinished),
    .streamValid(streamValid),
    .streamData(streamData),
    .streamReady(streamReady),
    .count(count),
    .error(error),
    .drained(drained)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue holding buffered words in order.
  logic [W-1:0] mq[$];
  bit           m_err;
  bit           m_drn;
  bit           chk_en = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      m_err  = 1'b0;
      m_drn  = 1'b0;
      chk_en = 1'b1;
    end else begin
      bit n_empty, do_pop, do_push, fin;
      n_empty = (mq.size() != 0);
      do_pop  = n_empty && streamReady;
      do_push = outValid && !m_drn && ((mq.size() < NOUT) || do_pop);
      fin     = programFinished && !n_empty && 1'b0;
      fin     = programFinished && (mq.size() == 0) && !outValid;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(outData);
      if (outValid && !do_push) m_err = 1'b1;
      if (fin) m_drn = 1'b1;
    end
  end

  // Words actually handed to the consumer, in order.
  logic [W-1:0] got[$];

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("count",       32'(count),       32'(mq.size()));
      check("streamValid", 32'(streamValid), 32'(mq.size() != 0));
      check("streamData",  32'(streamData),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      check("error",       32'(error),       32'(m_err));
      check("drained",     32'(drained),     32'(m_drn));
      check("count_bound", 32'(count <= CW'(NOUT)), 32'd1);
      if (streamValid && streamReady) got.push_back(streamData);
    end
  end

  // Apply one set of inputs across one clock edge; return 2 time units after it.
  task automatic cyc(input logic ov, input logic [W-1:0] d, input logic rdy, input logic fin);
    outValid        = ov;
    outData         = d;
    streamReady     = rdy;
    programFinished = fin;
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    got.delete();
  endtask

  task automatic check_got(input string name, input logic [W-1:0] exp[$]);
    check({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check(name, 32'(got[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    reset = 1'b1; outValid = 1'b0; outData = '0; streamReady = 1'b0; programFinished = 1'b0;
    @(posedge clock); #2;

    // Reset state
    do_reset();
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(streamValid), 32'd0);
    check("rst_data",  32'(streamData), 32'd0);
    check("rst_flags", 32'({error, drained}), 32'd0);

    // 1. Basic stream with consumer always ready
    cyc(1'b1, W'(3), 1'b1, 1'b0);
    check("t1_first_lat", 32'({streamValid, streamData}), 32'h1003);
    cyc(1'b1, W'(0), 1'b1, 1'b0);
    check("t1_count", 32'(count), 32'd1);
    cyc(1'b1, W'(1), 1'b1, 1'b0);
    check("t1_count2", 32'(count), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    check("t1_empty", 32'(count), 32'd0);
    check("t1_not_yet_drained", 32'(drained), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    check("t1_drained", 32'(drained), 32'd1);
    check("t1_error", 32'(error), 32'd0);
    check_got("t1_stream", '{W'(3), W'(0), W'(1)});

    // 2. Backpressure and overflow
    do_reset();
    cyc(1'b1, W'(5), 1'b0, 1'b0);
    cyc(1'b1, W'(6), 1'b0, 1'b0);
    cyc(1'b1, W'(7), 1'b0, 1'b0);
    check("t2_err_before", 32'(error), 32'd0);
    cyc(1'b1, W'(8), 1'b0, 1'b0);
    check("t2_count", 32'(count), 32'd3);
    check("t2_error", 32'(error), 32'd1);
    check("t2_hold", 32'(streamData), 32'd5);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    check_got("t2_stream", '{W'(5), W'(6), W'(7)});

    // 3. Full pass-through
    do_reset();
    cyc(1'b1, W'(1), 1'b0, 1'b0);
    cyc(1'b1, W'(2), 1'b0, 1'b0);
    cyc(1'b1, W'(3), 1'b0, 1'b0);
    cyc(1'b1, W'(4), 1'b1, 1'b0);
    check("t3_count", 32'(count), 32'd3);
    check("t3_error", 32'(error), 32'd0);
    check("t3_head", 32'(streamData), 32'd2);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    check_got("t3_stream", '{W'(1), W'(2), W'(3), W'(4)});

    // 4. Pointer wrap with ready gaps that stay within depth
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, W'(i), (i % 4) != 0, 1'b0);
    check("t4_count", 32'(count), 32'd3);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    check("t4_error", 32'(error), 32'd0);
    check_got("t4_stream", '{W'(0), W'(1), W'(2), W'(3), W'(4), W'(5), W'(6), W'(7), W'(8), W'(9)});

    // 5. Reset mid-operation
    do_reset();
    cyc(1'b1, W'(1), 1'b0, 1'b0);
    cyc(1'b1, W'(2), 1'b0, 1'b0);
    check("t5_count_pre", 32'(count), 32'd2);
    do_reset();
    check("t5_count", 32'(count), 32'd0);
    check("t5_valid", 32'(streamValid), 32'd0);
    check("t5_flags", 32'({error, drained}), 32'd0);
    cyc(1'b1, W'(9), 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check_got("t5_stream", '{W'(9)});

    // 6. Late write after drain
    do_reset();
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("t6_drained", 32'(drained), 32'd1);
    cyc(1'b1, W'(7), 1'b1, 1'b1);
    check("t6_count", 32'(count), 32'd0);
    check("t6_error", 32'(error), 32'd1);
    check("t6_drained_hold", 32'(drained), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    check("t6_no_stream", 32'(got.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
